// File: rtl/data_inf_rr_merge_if.sv
// Stream bundle for the round-robin merger: NUM input channels in, one merged stream out.
interface data_inf_rr_merge_if #(
  parameter int NUM   = 4,
  parameter int DSIZE = 8
);
  localparam int CW = $clog2(NUM);

  logic [NUM-1:0]       in_valid;
  logic [NUM*DSIZE-1:0] in_data;
  logic [NUM-1:0]       in_last;
  logic [NUM-1:0]       in_ready;
  logic                 out_valid;
  logic [DSIZE-1:0]     out_data;
  logic                 out_last;
  logic [CW-1:0]        out_chan;
  logic                 out_ready;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_chan
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_chan
  );
endinterface

// File: rtl/data_inf_rr_merge.sv
// N-channel valid/ready merger: round-robin grant, optional packet lock, one registered output stage.
//  state | meaning
//  ARB   | per-beat round-robin search starting after last_grant
//  LOCK  | grant pinned to lock_chan until its in_last beat transfers
module data_inf_rr_merge #(
  parameter int NUM      = 4,
  parameter int DSIZE    = 8,
  parameter int PKT_MODE = 0
) (
  input logic               clock,
  input logic               rst_n,
  data_inf_rr_merge_if.slave bus
);
  localparam int CW = $clog2(NUM);

  typedef enum logic {ARB, LOCK} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    last_grant_q, last_grant_d;
  logic [CW-1:0]    lock_chan_q, lock_chan_d;
  logic             out_valid_q, out_valid_d;
  logic [DSIZE-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic [CW-1:0]    out_chan_q, out_chan_d;

  logic [CW-1:0]    grant;
  logic [CW-1:0]    cand;
  logic             grant_valid;
  logic             accept;
  logic             xfer;
  logic [DSIZE-1:0] sel_data;

  function automatic logic [CW-1:0] wrap_add(input logic [CW-1:0] base, input int k);
    int s;
    s = (int'(base) + k) % NUM;
    return CW'(s);
  endfunction

  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    cand        = '0;
    if (state_q == LOCK) begin
      grant       = lock_chan_q;
      grant_valid = bus.in_valid[lock_chan_q];
    end else begin
      for (int k = 1; k <= NUM; k++) begin
        cand = wrap_add(last_grant_q, k);
        if (!grant_valid && bus.in_valid[cand]) begin
          grant       = cand;
          grant_valid = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM; i++) begin
      if (grant == CW'(i)) sel_data = bus.in_data[i*DSIZE +: DSIZE];
    end
  end

  assign accept = !out_valid_q || bus.out_ready;
  // grant_valid already implies in_valid of the granted channel
  assign xfer   = accept && grant_valid && rst_n;

  always_comb begin
    bus.in_ready = '0;
    if (xfer) bus.in_ready[grant] = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    lock_chan_d  = lock_chan_q;
    last_grant_d = last_grant_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    out_chan_d   = out_chan_q;

    if (xfer) begin
      last_grant_d = grant;
      out_valid_d  = 1'b1;
      out_data_d   = sel_data;
      out_chan_d   = grant;
      out_last_d   = (PKT_MODE != 0) && bus.in_last[grant];
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ARB: begin
        if ((PKT_MODE != 0) && xfer && !bus.in_last[grant]) begin
          state_d     = LOCK;
          lock_chan_d = grant;
        end
      end
      LOCK: begin
        if (xfer && bus.in_last[grant]) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB;
      last_grant_q <= CW'(NUM - 1);
      lock_chan_q  <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      out_chan_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      lock_chan_q  <= lock_chan_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      out_chan_q   <= out_chan_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_chan  = out_chan_q;
endmodule

// File: tb/tb_data_inf_rr_merge.sv
// Directed checks of the round-robin merger (per-beat and packet mode) plus a short random scoreboard run.
module tb_data_inf_rr_merge;
  logic clock = 1'b0;
  logic rst_n;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  data_inf_rr_merge_if #(.NUM(4), .DSIZE(8))  if_rr ();
  data_inf_rr_merge_if #(.NUM(4), .DSIZE(8))  if_pk ();
  data_inf_rr_merge_if #(.NUM(3), .DSIZE(16)) if_rnd ();

  data_inf_rr_merge #(.NUM(4), .DSIZE(8), .PKT_MODE(0)) u_rr (
    .clock(clock), .rst_n(rst_n), .bus(if_rr));
  data_inf_rr_merge #(.NUM(4), .DSIZE(8), .PKT_MODE(1)) u_pk (
    .clock(clock), .rst_n(rst_n), .bus(if_pk));
  data_inf_rr_merge #(.NUM(3), .DSIZE(16), .PKT_MODE(1)) u_rnd (
    .clock(clock), .rst_n(rst_n), .bus(if_rnd));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drv_rr(input logic [3:0] v, input logic [31:0] d, input logic [3:0] l, input logic ordy);
    @(negedge clock);
    if_rr.in_valid  = v;
    if_rr.in_data   = d;
    if_rr.in_last   = l;
    if_rr.out_ready = ordy;
    #1;
  endtask

  task automatic drv_pk(input logic [3:0] v, input logic [31:0] d, input logic [3:0] l, input logic ordy);
    @(negedge clock);
    if_pk.in_valid  = v;
    if_pk.in_data   = d;
    if_pk.in_last   = l;
    if_pk.out_ready = ordy;
    #1;
  endtask

  task automatic chk_pk_out(input string tag, input logic [1:0] ch, input logic [7:0] d, input logic l);
    check({tag, "_valid"}, if_pk.out_valid, 1);
    check({tag, "_chan"},  if_pk.out_chan,  ch);
    check({tag, "_data"},  if_pk.out_data,  d);
    check({tag, "_last"},  if_pk.out_last,  l);
  endtask

  logic [13:0] seq[3];
  logic [13:0] exp_seq[3];
  int          rem[3];
  logic        vld[3];
  logic        hs[3];
  logic [18:0] sb[$];
  logic [18:0] front;
  int          pkt_chan;
  int          n_push, n_pop;

  initial begin
    rst_n = 1'b0;
    if_rr.in_valid = 4'hf; if_rr.in_data = '0; if_rr.in_last = '0; if_rr.out_ready = 1'b1;
    if_pk.in_valid = '0;   if_pk.in_data = '0; if_pk.in_last = '0; if_pk.out_ready = 1'b1;
    if_rnd.in_valid = '0;  if_rnd.in_data = '0; if_rnd.in_last = '0; if_rnd.out_ready = 1'b1;
    #3;
    check("rst_in_ready",  if_rr.in_ready,  0);
    check("rst_out_valid", if_rr.out_valid, 0);
    check("rst_out_data",  if_rr.out_data,  0);
    check("rst_out_chan",  if_rr.out_chan,  0);
    check("rst_out_last",  if_pk.out_last,  0);
    if_rr.in_valid = '0;
    @(negedge clock);
    @(negedge clock);
    rst_n = 1'b1;

    // all channels valid: strict 0,1,2,3 rotation, one beat per cycle
    for (int c = 0; c < 8; c++) begin
      drv_rr(4'hf, 32'h13121110, 4'h0, 1'b1);
      check("t1_ready", if_rr.in_ready, 32'(1) << (c % 4));
      if (c == 0) check("t1_first_valid", if_rr.out_valid, 0);
      else begin
        check("t1_valid", if_rr.out_valid, 1);
        check("t1_chan",  if_rr.out_chan,  (c - 1) % 4);
        check("t1_data",  if_rr.out_data,  32'h10 + ((c - 1) % 4));
      end
    end

    // backpressure hold on a lone channel
    drv_rr(4'h0, 32'h0, 4'h0, 1'b1);
    check("t2_last_chan", if_rr.out_chan, 3);
    check("t2_last_data", if_rr.out_data, 8'h13);
    drv_rr(4'b0100, 32'h00A50000, 4'h0, 1'b0);
    check("t2_drained",   if_rr.out_valid, 0);
    check("t2_hold_data", if_rr.out_data,  8'h13);
    check("t2_ready",     if_rr.in_ready,  4'b0100);
    for (int c = 0; c < 3; c++) begin
      drv_rr(4'b0100, 32'h00A50000, 4'h0, 1'b0);
      check("t2_stall_ready", if_rr.in_ready,  0);
      check("t2_stall_valid", if_rr.out_valid, 1);
      check("t2_stall_data",  if_rr.out_data,  8'hA5);
      check("t2_stall_chan",  if_rr.out_chan,  2);
    end
    drv_rr(4'b0100, 32'h00A50000, 4'h0, 1'b1);
    check("t2_release_ready", if_rr.in_ready, 4'b0100);
    drv_rr(4'h0, 32'h0, 4'h0, 1'b1);
    check("t2_b2b_valid", if_rr.out_valid, 1);
    check("t2_b2b_data",  if_rr.out_data,  8'hA5);
    drv_rr(4'h0, 32'h0, 4'h0, 1'b1);
    check("t2_empty", if_rr.out_valid, 0);

    // packet mode: ch1 3-beat packet holds the grant against ch0/ch3
    drv_pk(4'b0010, 32'h00002100, 4'b0000, 1'b1);
    check("t3_ready0", if_pk.in_ready, 4'b0010);
    check("t3_idle",   if_pk.out_valid, 0);
    drv_pk(4'b1011, 32'h31002201, 4'b1001, 1'b1);
    check("t3_ready1", if_pk.in_ready, 4'b0010);
    chk_pk_out("t3_b1", 2'd1, 8'h21, 1'b0);
    drv_pk(4'b1011, 32'h31002301, 4'b1011, 1'b1);
    check("t3_ready2", if_pk.in_ready, 4'b0010);
    chk_pk_out("t3_b2", 2'd1, 8'h22, 1'b0);
    drv_pk(4'b1001, 32'h31000001, 4'b1001, 1'b1);
    check("t3_ready3", if_pk.in_ready, 4'b1000);
    chk_pk_out("t3_b3", 2'd1, 8'h23, 1'b1);
    drv_pk(4'b0001, 32'h00000001, 4'b0001, 1'b1);
    check("t3_ready4", if_pk.in_ready, 4'b0001);
    chk_pk_out("t3_ch3", 2'd3, 8'h31, 1'b1);
    drv_pk(4'b0000, 32'h0, 4'b0000, 1'b1);
    chk_pk_out("t3_ch0", 2'd0, 8'h01, 1'b1);

    // packet mode: valid gap inside a locked packet does not release the lock
    drv_pk(4'b0011, 32'h00004105, 4'b0001, 1'b1);
    check("t4_ready0", if_pk.in_ready, 4'b0010);
    drv_pk(4'b0001, 32'h00000005, 4'b0001, 1'b1);
    check("t4_gap1", if_pk.in_ready, 0);
    chk_pk_out("t4_b1", 2'd1, 8'h41, 1'b0);
    drv_pk(4'b0001, 32'h00000005, 4'b0001, 1'b1);
    check("t4_gap2", if_pk.in_ready, 0);
    check("t4_gap2_valid", if_pk.out_valid, 0);
    drv_pk(4'b0011, 32'h00004205, 4'b0011, 1'b1);
    check("t4_ready3", if_pk.in_ready, 4'b0010);
    drv_pk(4'b0001, 32'h00000005, 4'b0001, 1'b1);
    check("t4_ready4", if_pk.in_ready, 4'b0001);
    chk_pk_out("t4_b2", 2'd1, 8'h42, 1'b1);
    drv_pk(4'b0000, 32'h0, 4'b0000, 1'b1);
    chk_pk_out("t4_ch0", 2'd0, 8'h05, 1'b1);

    // reset in LOCK with a full output register
    drv_pk(4'b0100, 32'h00770000, 4'b0000, 1'b1);
    check("t5_ready0", if_pk.in_ready, 4'b0100);
    drv_pk(4'b0101, 32'h00770005, 4'b0001, 1'b0);
    check("t5_full_valid", if_pk.out_valid, 1);
    check("t5_full_ready", if_pk.in_ready, 0);
    rst_n = 1'b0;
    #1;
    check("t5_async_valid", if_pk.out_valid, 0);
    if_pk.out_ready = 1'b1;
    #1;
    check("t5_rst_ready", if_pk.in_ready, 0);
    @(posedge clock);
    #2 rst_n = 1'b1;
    drv_pk(4'b0101, 32'h00770005, 4'b0001, 1'b1);
    check("t5_regrant", if_pk.in_ready, 4'b0001);
    check("t5_post_valid", if_pk.out_valid, 0);
    drv_pk(4'b0000, 32'h0, 4'b0000, 1'b1);
    chk_pk_out("t5_ch0", 2'd0, 8'h05, 1'b1);

    // random traffic on NUM=3, DSIZE=16 packet merger
    pkt_chan = -1;
    n_push = 0;
    n_pop = 0;
    for (int c = 0; c < 3; c++) begin
      seq[c] = '0; exp_seq[c] = '0; vld[c] = 1'b0; hs[c] = 1'b0;
      rem[c] = $urandom_range(1, 4);
    end
    for (int cyc = 0; cyc < 1540; cyc++) begin
      @(negedge clock);
      for (int c = 0; c < 3; c++) begin
        if (hs[c]) begin
          seq[c]++;
          rem[c]--;
          if (rem[c] == 0) rem[c] = $urandom_range(1, 4);
          vld[c] = 1'b0;
        end
        if (!vld[c] && cyc < 1500) vld[c] = ($urandom_range(0, 1) == 1);
        if_rnd.in_valid[c] = vld[c];
        if_rnd.in_data[c*16 +: 16] = {2'(c), seq[c]};
        if_rnd.in_last[c] = (rem[c] == 1);
      end
      if_rnd.out_ready = (cyc >= 1500) ? 1'b1 : ($urandom_range(0, 3) != 0);
      #1;
      check("t6_onehot", 32'($onehot0(if_rnd.in_ready)), 1);
      if (if_rnd.out_valid && if_rnd.out_ready) begin
        check("t6_sb_nonempty", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          front = sb.pop_front();
          n_pop++;
          check("t6_beat", {if_rnd.out_chan, if_rnd.out_last, if_rnd.out_data}, front);
          check("t6_seq", if_rnd.out_data[13:0], exp_seq[if_rnd.out_chan]);
          exp_seq[if_rnd.out_chan]++;
          if (pkt_chan >= 0) check("t6_interleave", if_rnd.out_chan, pkt_chan);
          pkt_chan = if_rnd.out_last ? -1 : int'(if_rnd.out_chan);
        end
      end
      for (int c = 0; c < 3; c++) begin
        hs[c] = vld[c] && if_rnd.in_ready[c];
        if (hs[c]) begin
          sb.push_back({2'(c), if_rnd.in_last[c], if_rnd.in_data[c*16 +: 16]});
          n_push++;
        end
      end
    end
    check("t6_drained", sb.size(), 0);
    check("t6_count", n_pop, n_push);
    check("t6_enough_beats", 32'(n_push > 500), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
